adc_result_fifo: RTL and testbench

- Buffers conversion results downstream of the SAR control/oversampling path.
- Input side: single-cycle strobe plus result word. The ADC cannot be stalled, so there is no backpressure toward it.
- Output side: first-word-fall-through valid/ready stream for a bus or readout interface.
- Also provides a fill level, sticky overflow, a saturating drop counter and a threshold interrupt, so software can read bursts of results without losing samples silently.

---
 rtl/adc_pkg.sv | 12 +
 rtl/adc_fifo_mem.sv | 27 ++
 rtl/adc_result_fifo.sv | 107 ++++++++++
 tb/tb_adc_result_fifo.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// Shared constants and types for the ADC result path.
// Widths here are the defaults that the FIFO and its memory are built from.
package adc_pkg;

    localparam int ADC_RESULT_W       = 16;
    localparam int ADC_FIFO_DEPTH_DEF = 8;
    localparam int ADC_TAG_W          = 4;
    localparam int ADC_DROP_CNT_W     = 8;

    typedef logic [ADC_RESULT_W-1:0] adc_result_t;

endpackage

// File: rtl/adc_fifo_mem.sv
// Register-array storage: one synchronous write port, one combinational read port.
// Latency: a write is readable the cycle after its edge; reads are zero-latency.
// Backpressure: none; the caller decides when writing is allowed.
module adc_fifo_mem #(
    parameter  int WIDTH  = 16,
    parameter  int DEPTH  = 8,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/adc_result_fifo.sv
// FWFT result FIFO with level, sticky overflow, drop counter and threshold irq; ADC_RESULT_FIFO_TAG_EN adds rd_tag_out.
// Latency: a written word is on rd_data_out one cycle after its strobe; irq_out lags the level by one cycle.
// Backpressure: none toward the ADC; writes while full are dropped and counted, reads follow rd_ready_in.
module adc_result_fifo
    import adc_pkg::*;
#(
    parameter  int DATA_W = ADC_RESULT_W,
    parameter  int DEPTH  = ADC_FIFO_DEPTH_DEF,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_strobe_in,
    input  logic [DATA_W-1:0]         wr_data_in,
    output logic                      rd_valid_out,
    output logic [DATA_W-1:0]         rd_data_out,
    input  logic                      rd_ready_in,
`ifdef ADC_RESULT_FIFO_TAG_EN
    output logic [ADC_TAG_W-1:0]      rd_tag_out,
`endif
    input  logic                      clear_in,
    input  logic [ADDR_W:0]           thresh_in,
    output logic [ADDR_W:0]           level_out,
    output logic                      overflow_out,
    output logic [ADC_DROP_CNT_W-1:0] drop_count_out,
    output logic                      irq_out
);

`ifdef ADC_RESULT_FIFO_TAG_EN
    localparam int MEM_W = DATA_W + ADC_TAG_W;
`else
    localparam int MEM_W = DATA_W;
`endif

    logic [ADDR_W:0]  wptr, rptr;
    logic [ADDR_W:0]  wptr_nxt, rptr_nxt;
    logic             empty, full;
    logic             do_wr, do_rd, do_drop;
    logic [MEM_W-1:0] mem_wr_word, mem_rd_word;

    assign empty = (wptr == rptr);
    assign full  = (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]) && (wptr[ADDR_W] != rptr[ADDR_W]);

    // Clear wins over both ports; a full FIFO never reuses the slot freed by a same-cycle read.
    assign do_wr   = wr_strobe_in && !full && !clear_in;
    assign do_drop = wr_strobe_in &&  full && !clear_in;
    assign do_rd   = rd_ready_in  && !empty && !clear_in;

    assign wptr_nxt = wptr + (ADDR_W+1)'(do_wr);
    assign rptr_nxt = rptr + (ADDR_W+1)'(do_rd);

    always_ff @(posedge clk) begin
        if (rst || clear_in) begin
            wptr           <= '0;
            rptr           <= '0;
            level_out      <= '0;
            overflow_out   <= 1'b0;
            drop_count_out <= '0;
            irq_out        <= 1'b0;
        end else begin
            wptr      <= wptr_nxt;
            rptr      <= rptr_nxt;
            level_out <= wptr_nxt - rptr_nxt;
            irq_out   <= (thresh_in != '0) && (level_out >= thresh_in);
            if (do_drop) begin
                overflow_out <= 1'b1;
                if (drop_count_out != '1) begin
                    drop_count_out <= drop_count_out + 1'b1;
                end
            end
        end
    end

`ifdef ADC_RESULT_FIFO_TAG_EN
    // Sequence number advances on every strobe so dropped samples leave a gap in the stored tags.
    logic [ADC_TAG_W-1:0] tag_cnt;

    always_ff @(posedge clk) begin
        if (rst || clear_in) begin
            tag_cnt <= '0;
        end else if (wr_strobe_in) begin
            tag_cnt <= tag_cnt + 1'b1;
        end
    end

    assign mem_wr_word = {tag_cnt, wr_data_in};
    assign rd_tag_out  = mem_rd_word[DATA_W +: ADC_TAG_W];
`else
    assign mem_wr_word = wr_data_in;
`endif

    adc_fifo_mem #(
        .WIDTH (MEM_W),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (do_wr),
        .wr_addr (wptr[ADDR_W-1:0]),
        .wr_data (mem_wr_word),
        .rd_addr (rptr[ADDR_W-1:0]),
        .rd_data (mem_rd_word)
    );

    assign rd_valid_out = !empty;
    assign rd_data_out  = mem_rd_word[DATA_W-1:0];

endmodule

// File: tb/tb_adc_result_fifo.sv
// Directed bench for adc_result_fifo with a queue-based reference model checked every cycle.
module tb_adc_result_fifo;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_strobe_in;
    logic [15:0] wr_data_in;
    logic        rd_valid_out;
    logic [15:0] rd_data_out;
    logic        rd_ready_in;
    logic        clear_in;
    logic [3:0]  thresh_in;
    logic [3:0]  level_out;
    logic        overflow_out;
    logic [7:0]  drop_count_out;
    logic        irq_out;
`ifdef ADC_RESULT_FIFO_TAG_EN
    logic [3:0]  rd_tag_out;
`endif

    adc_result_fifo #(.DATA_W(16), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .wr_strobe_in   (wr_strobe_in),
        .wr_data_in     (wr_data_in),
        .rd_valid_out   (rd_valid_out),
        .rd_data_out    (rd_data_out),
        .rd_ready_in    (rd_ready_in),
`ifdef ADC_RESULT_FIFO_TAG_EN
        .rd_tag_out     (rd_tag_out),
`endif
        .clear_in       (clear_in),
        .thresh_in      (thresh_in),
        .level_out      (level_out),
        .overflow_out   (overflow_out),
        .drop_count_out (drop_count_out),
        .irq_out        (irq_out)
    );

    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;
    bit chk_en    = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Reference model: a plain queue of words (and tags) plus status counters.
    logic [15:0] mq[$];
    logic [3:0]  mtq[$];
    bit          m_ovf;
    int          m_drops;
    bit          m_irq;
    logic [3:0]  m_tag;

    always @(posedge clk) begin
        int  n;
        bit  was_full;
        if (rst || clear_in) begin
            mq.delete();
            mtq.delete();
            m_ovf   = 1'b0;
            m_drops = 0;
            m_irq   = 1'b0;
            m_tag   = 4'd0;
        end else begin
            n        = mq.size();
            was_full = (n == DEPTH);
            m_irq    = (thresh_in != 0) && (n >= int'(thresh_in));
            if (rd_ready_in && n > 0) begin
                void'(mq.pop_front());
                void'(mtq.pop_front());
            end
            if (wr_strobe_in) begin
                if (!was_full) begin
                    mq.push_back(wr_data_in);
                    mtq.push_back(m_tag);
                end else begin
                    m_ovf = 1'b1;
                    if (m_drops < 255) m_drops++;
                end
                m_tag = m_tag + 4'd1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_level", 32'(level_out), 32'(mq.size()));
            chk("m_valid", 32'(rd_valid_out), 32'(mq.size() != 0));
            chk("m_ovf",   32'(overflow_out), 32'(m_ovf));
            chk("m_drops", 32'(drop_count_out), 32'(m_drops));
            chk("m_irq",   32'(irq_out), 32'(m_irq));
            if (mq.size() != 0) begin
                chk("m_data", 32'(rd_data_out), 32'(mq[0]));
`ifdef ADC_RESULT_FIFO_TAG_EN
                chk("m_tag", 32'(rd_tag_out), 32'(mtq[0]));
`endif
            end
        end
    end

    task automatic step(input logic s, input logic [15:0] d, input logic r);
        wr_strobe_in = s;
        wr_data_in   = d;
        rd_ready_in  = r;
        @(negedge clk);
        wr_strobe_in = 1'b0;
        rd_ready_in  = 1'b0;
    endtask

    task automatic do_clear();
        clear_in = 1'b1;
        @(negedge clk);
        clear_in = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        wr_strobe_in = 1'b0;
        wr_data_in   = 16'h0;
        rd_ready_in  = 1'b0;
        clear_in     = 1'b0;
        thresh_in    = 4'd0;
        repeat (2) @(negedge clk);
        rst    = 1'b0;
        chk_en = 1'b1;
        chk("rst_level", 32'(level_out), 32'd0);
        chk("rst_valid", 32'(rd_valid_out), 32'd0);
        chk("rst_ovf",   32'(overflow_out), 32'd0);
        chk("rst_drops", 32'(drop_count_out), 32'd0);
        chk("rst_irq",   32'(irq_out), 32'd0);

        // Basic order
        step(1'b1, 16'h0123, 1'b0);
        chk("first_fallthrough", 32'(rd_data_out), 32'h0123);
        step(1'b1, 16'h0456, 1'b0);
        step(1'b1, 16'h0789, 1'b0);
        chk("basic_level", 32'(level_out), 32'd3);
        chk("basic_valid", 32'(rd_valid_out), 32'd1);
        chk("basic_head0", 32'(rd_data_out), 32'h0123);
        step(1'b0, 16'h0, 1'b1);
        chk("basic_head1", 32'(rd_data_out), 32'h0456);
        step(1'b0, 16'h0, 1'b1);
        chk("basic_head2", 32'(rd_data_out), 32'h0789);
        step(1'b0, 16'h0, 1'b1);
        chk("basic_empty_level", 32'(level_out), 32'd0);
        chk("basic_empty_valid", 32'(rd_valid_out), 32'd0);
        step(1'b0, 16'h0, 1'b1);
        chk("ready_on_empty", 32'(level_out), 32'd0);

        // Overflow and drop saturation
        for (int i = 1; i <= 8; i++) step(1'b1, 16'(i), 1'b0);
        step(1'b1, 16'hBEEF, 1'b0);
        chk("ovf_level", 32'(level_out), 32'd8);
        chk("ovf_flag",  32'(overflow_out), 32'd1);
        chk("ovf_drops", 32'(drop_count_out), 32'd1);
        for (int i = 0; i < 300; i++) step(1'b1, 16'hDEAD, 1'b0);
        chk("drops_sat", 32'(drop_count_out), 32'd255);
        for (int i = 1; i <= 8; i++) begin
            chk("ovf_readout", 32'(rd_data_out), 32'(i));
            step(1'b0, 16'h0, 1'b1);
        end
        chk("ovf_drained", 32'(rd_valid_out), 32'd0);
        chk("ovf_sticky",  32'(overflow_out), 32'd1);
        do_clear();

        // Threshold interrupt
        thresh_in = 4'd4;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 16'h3000 + 16'(i), 1'b0);
            chk("irq_low_fill", 32'(irq_out), 32'd0);
        end
        step(1'b0, 16'h0, 1'b0);
        chk("irq_rise", 32'(irq_out), 32'd1);
        step(1'b0, 16'h0, 1'b1);
        chk("irq_level3", 32'(level_out), 32'd3);
        chk("irq_hold", 32'(irq_out), 32'd1);
        step(1'b0, 16'h0, 1'b0);
        chk("irq_fall", 32'(irq_out), 32'd0);
        thresh_in = 4'd0;
        for (int i = 0; i < 5; i++) step(1'b1, 16'h3100 + 16'(i), 1'b0);
        step(1'b0, 16'h0, 1'b0);
        chk("irq_disabled_level", 32'(level_out), 32'd8);
        chk("irq_disabled", 32'(irq_out), 32'd0);
        do_clear();

        // Simultaneous read and write
        step(1'b1, 16'h4001, 1'b0);
        step(1'b1, 16'h4002, 1'b0);
        step(1'b1, 16'h4003, 1'b1);
        chk("rw_level2", 32'(level_out), 32'd2);
        chk("rw_head",   32'(rd_data_out), 32'h4002);
        for (int i = 4; i < 10; i++) step(1'b1, 16'h4000 + 16'(i), 1'b0);
        chk("rw_full", 32'(level_out), 32'd8);
        step(1'b1, 16'hDEAD, 1'b1);
        chk("rw_full_level", 32'(level_out), 32'd7);
        chk("rw_full_ovf",   32'(overflow_out), 32'd1);
        chk("rw_full_drops", 32'(drop_count_out), 32'd1);

        // Clear priority
        step(1'b0, 16'h0, 1'b1);
        step(1'b0, 16'h0, 1'b1);
        chk("clr_pre_level", 32'(level_out), 32'd5);
        clear_in = 1'b1;
        step(1'b1, 16'hAAAA, 1'b1);
        clear_in = 1'b0;
        chk("clr_level", 32'(level_out), 32'd0);
        chk("clr_valid", 32'(rd_valid_out), 32'd0);
        chk("clr_ovf",   32'(overflow_out), 32'd0);
        chk("clr_drops", 32'(drop_count_out), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 16'h0, 1'b1);
            chk("clr_no_aaaa", 32'(rd_valid_out), 32'd0);
        end

        // Reset mid-stream
        step(1'b1, 16'h5001, 1'b0);
        step(1'b1, 16'h5002, 1'b1);
        rst = 1'b1;
        step(1'b1, 16'h5003, 1'b1);
        rst = 1'b0;
        chk("mid_rst_level", 32'(level_out), 32'd0);
        chk("mid_rst_valid", 32'(rd_valid_out), 32'd0);

`ifdef ADC_RESULT_FIFO_TAG_EN
        // Sequence tags: eight stored, one dropped, one read, one more stored
        for (int i = 0; i < 8; i++) step(1'b1, 16'h6000 + 16'(i), 1'b0);
        step(1'b1, 16'h60FF, 1'b0);
        chk("tag_first", 32'(rd_tag_out), 32'd0);
        step(1'b0, 16'h0, 1'b1);
        step(1'b1, 16'h6009, 1'b0);
        for (int i = 1; i <= 8; i++) begin
            chk("tag_readout", 32'(rd_tag_out), (i == 8) ? 32'd9 : 32'(i));
            step(1'b0, 16'h0, 1'b1);
        end
`endif

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
